// File: rtl/himm_axil_cfg_loader.sv
// AXI4-Lite master that writes a block of configuration words into the himm register slave,
// optionally reads each word back to verify it, and reports completion plus the first error.
module himm_axil_cfg_loader #(
   parameter int unsigned NUM_REGS  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter bit          VERIFY    = 1'b1,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   start,
   input  logic [32*NUM_REGS-1:0] cfg_data,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             err_code,
   output logic [3:0]             err_index,
   output logic [31:0]            M_AXI_AWADDR,
   output logic [2:0]             M_AXI_AWPROT,
   output logic                   M_AXI_AWVALID,
   input  logic                   M_AXI_AWREADY,
   output logic [31:0]            M_AXI_WDATA,
   output logic [3:0]             M_AXI_WSTRB,
   output logic                   M_AXI_WVALID,
   input  logic                   M_AXI_WREADY,
   input  logic [1:0]             M_AXI_BRESP,
   input  logic                   M_AXI_BVALID,
   output logic                   M_AXI_BREADY,
   output logic [31:0]            M_AXI_ARADDR,
   output logic [2:0]             M_AXI_ARPROT,
   output logic                   M_AXI_ARVALID,
   input  logic                   M_AXI_ARREADY,
   input  logic [31:0]            M_AXI_RDATA,
   input  logic [1:0]             M_AXI_RRESP,
   input  logic                   M_AXI_RVALID,
   output logic                   M_AXI_RREADY
);

   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]    LAST_IDX = 4'(NUM_REGS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR    = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [2:0] ERR_OK    = 3'd0;
   localparam logic [2:0] ERR_BRESP = 3'd1;
   localparam logic [2:0] ERR_RRESP = 3'd2;
   localparam logic [2:0] ERR_CMP   = 3'd3;
   localparam logic [2:0] ERR_TMO   = 3'd4;

   logic [2:0]              state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    aw_pend_q, aw_pend_d;
   logic                    w_pend_q, w_pend_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [2:0]              err_code_q, err_code_d;
   logic [3:0]              err_index_q, err_index_d;
   logic [32*NUM_REGS-1:0]  shadow_q;
   logic                    load_shadow;
   logic                    hs;
   logic                    wait_st;
   logic                    last;
   logic [3:0]              idx_nxt;

   assign wait_st = (state_q == S_WR) || (state_q == S_WRESP) ||
                    (state_q == S_RD) || (state_q == S_RDATA);
   assign last    = (idx_q == LAST_IDX);
   assign idx_nxt = idx_q + 4'd1;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      aw_pend_d   = aw_pend_q;
      w_pend_d    = w_pend_q;
      tmo_d       = '0;
      err_code_d  = err_code_q;
      err_index_d = err_index_q;
      load_shadow = 1'b0;
      hs          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_shadow = 1'b1;
               idx_d       = 4'd0;
               addr_d      = BASE_ADDR;
               wdata_d     = cfg_data[31:0];
               aw_pend_d   = 1'b1;
               w_pend_d    = 1'b1;
               err_code_d  = ERR_OK;
               err_index_d = 4'd0;
               state_d     = S_WR;
            end
         end
         S_WR: begin
            hs = (aw_pend_q && M_AXI_AWREADY) || (w_pend_q && M_AXI_WREADY);
            if (M_AXI_AWREADY) aw_pend_d = 1'b0;
            if (M_AXI_WREADY)  w_pend_d  = 1'b0;
            if ((!aw_pend_q || M_AXI_AWREADY) && (!w_pend_q || M_AXI_WREADY)) state_d = S_WRESP;
         end
         S_WRESP: begin
            hs = M_AXI_BVALID;
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  err_code_d  = ERR_BRESP;
                  err_index_d = idx_q;
                  state_d     = S_DONE;
               end else if (!last) begin
                  idx_d     = idx_nxt;
                  addr_d    = addr_q + 32'd4;
                  wdata_d   = shadow_q[32*idx_nxt +: 32];
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  idx_d   = 4'd0;
                  addr_d  = BASE_ADDR;
                  state_d = VERIFY ? S_RD : S_DONE;
               end
            end
         end
         S_RD: begin
            hs = M_AXI_ARREADY;
            if (M_AXI_ARREADY) state_d = S_RDATA;
         end
         S_RDATA: begin
            hs = M_AXI_RVALID;
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != 2'b00) begin
                  err_code_d  = ERR_RRESP;
                  err_index_d = idx_q;
                  state_d     = S_DONE;
               end else if (M_AXI_RDATA != shadow_q[32*idx_q +: 32]) begin
                  err_code_d  = ERR_CMP;
                  err_index_d = idx_q;
                  state_d     = S_DONE;
               end else if (last) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_nxt;
                  addr_d  = addr_q + 32'd4;
                  state_d = S_RD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Wait counter restarts on any handshake or state change; expiry abandons the transfer.
      if (wait_st && !hs && (state_d == state_q)) begin
         if (tmo_q == TMO_LAST) begin
            err_code_d  = ERR_TMO;
            err_index_d = idx_q;
            aw_pend_d   = 1'b0;
            w_pend_d    = 1'b0;
            state_d     = S_DONE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (ARESET) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         aw_pend_q   <= 1'b0;
         w_pend_q    <= 1'b0;
         tmo_q       <= '0;
         err_code_q  <= '0;
         err_index_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         aw_pend_q   <= aw_pend_d;
         w_pend_q    <= w_pend_d;
         tmo_q       <= tmo_d;
         err_code_q  <= err_code_d;
         err_index_q <= err_index_d;
      end
   end

   // NOTE: the shadow buffer is pure data, always loaded before use, so it carries no reset.
   always_ff @(posedge ACLK) begin
      if (load_shadow) shadow_q <= cfg_data;
   end

   assign busy          = wait_st;
   assign done          = (state_q == S_DONE);
   assign err_code      = err_code_q;
   assign err_index     = err_index_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = aw_pend_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = w_pend_q;
   assign M_AXI_BREADY  = (state_q == S_WRESP);
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = (state_q == S_RD);
   assign M_AXI_RREADY  = (state_q == S_RDATA);

endmodule
